// File: rtl/dsp_mac_pkg.sv
// Shared helpers for the dual-product MAC: pipeline latency, width-generic
// sign/zero extension and saturation bounds. Helpers work on a MAX_W-bit
// container so callers of any width up to MAX_W can use them and narrow the
// result with a width cast.
package dsp_mac_pkg;

    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned MAX_W    = 128;
    localparam int unsigned IDX_W    = $clog2(MAX_W);

    typedef logic [MAX_W-1:0] wide_t;

    // Keep the low w bits of v, clear the rest.
    function automatic wide_t zext(input wide_t v, input int unsigned w);
        wide_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) r[IDX_W'(i)] = v[IDX_W'(i)];
        end
        return r;
    endfunction

    // Replicate bit w-1 of v into every bit above it.
    function automatic wide_t sext(input wide_t v, input int unsigned w);
        wide_t            r;
        logic [IDX_W-1:0] top;
        r   = v;
        top = IDX_W'(w - 1);
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i >= w) r[IDX_W'(i)] = v[top];
        end
        return r;
    endfunction

    // Largest value representable in res_w bits, as a MAX_W two's-complement value.
    function automatic wide_t sat_max(input int unsigned res_w, input logic is_signed);
        wide_t one;
        one = wide_t'(1);
        return is_signed ? (one << (res_w - 1)) - one : (one << res_w) - one;
    endfunction

    // Smallest value representable in res_w bits, as a MAX_W two's-complement value.
    function automatic wide_t sat_min(input int unsigned res_w, input logic is_signed);
        wide_t one;
        one = wide_t'(1);
        return is_signed ? ~((one << (res_w - 1)) - one) : '0;
    endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle of one MAC instance.
//   master: drives enable, operands, control and cascade input; sees results.
//   slave : the MAC itself.
interface dsp_mac_pipe_if #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 18,
    parameter int unsigned ACC_W = 64,
    parameter int unsigned RES_W = 27
);
    logic             ena;
    logic             in_valid;
    logic [A_W-1:0]   ax;
    logic [B_W-1:0]   bx;
    logic [A_W-1:0]   ay;
    logic [B_W-1:0]   by;
    logic             accumulate;
    logic             chain_en;
    logic [ACC_W-1:0] chainin;
    logic             clear;
    logic             out_valid;
    logic [RES_W-1:0] resulta;
    logic [ACC_W-1:0] chainout;
    logic             ovf;

    modport master (
        output ena, in_valid, ax, bx, ay, by, accumulate, chain_en, chainin, clear,
        input  out_valid, resulta, chainout, ovf
    );

    modport slave (
        input  ena, in_valid, ax, bx, ay, by, accumulate, chain_en, chainin, clear,
        output out_valid, resulta, chainout, ovf
    );
endinterface

// File: rtl/dsp_mac_sat.sv
// Combinational narrowing of the accumulator to the result width.
//   acc_i : ACC_W accumulator value
//   res_c : RES_W result, clamped to the signed/unsigned RES_W range when SAT,
//           otherwise the low RES_W bits.
module dsp_mac_sat
    import dsp_mac_pkg::*;
#(
    parameter int unsigned ACC_W  = 64,
    parameter int unsigned RES_W  = 27,
    parameter bit          SIGNED = 1'b1,
    parameter bit          SAT    = 1'b1
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [RES_W-1:0] res_c
);

    localparam wide_t SAT_HI = sat_max(RES_W, SIGNED);
    localparam wide_t SAT_LO = sat_min(RES_W, SIGNED);

    wide_t acc_w;
    logic  hi;
    logic  lo;

    // Compare in the wide container so one path covers both signednesses.
    always_comb begin
        acc_w = SIGNED ? sext(MAX_W'(acc_i), ACC_W) : zext(MAX_W'(acc_i), ACC_W);
        hi    = SIGNED ? ($signed(acc_w) > $signed(SAT_HI)) : (acc_w > SAT_HI);
        lo    = SIGNED ? ($signed(acc_w) < $signed(SAT_LO)) : 1'b0;
        res_c = SAT ? RES_W'(hi ? SAT_HI : (lo ? SAT_LO : acc_w)) : acc_i[RES_W-1:0];
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined dual-product multiply-accumulate: ax*bx + ay*by, optionally plus
// the cascade input and the running accumulator. Three enabled cycles from
// in_valid to out_valid, one result per enabled cycle.
//   clk0, aclr0_n : clock, asynchronous active-low reset
//   bus (slave)   : ena stall, operands, accumulate/chain_en/clear controls,
//                   chainin; registered out_valid, resulta, chainout, ovf.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int unsigned A_W    = 8,
    parameter int unsigned B_W    = 18,
    parameter int unsigned ACC_W  = 64,
    parameter int unsigned RES_W  = 27,
    parameter bit          SIGNED = 1'b1,
    parameter bit          SAT    = 1'b1
) (
    input  logic           clk0,
    input  logic           aclr0_n,
    dsp_mac_pipe_if.slave  bus
);

    localparam int unsigned PW = A_W + B_W;   // single product width
    localparam int unsigned SW = PW + 1;      // product-sum width
    localparam int unsigned XW = ACC_W + 2;   // exact three-term sum width

    // Stage 1
    logic             v1_q;
    logic [A_W-1:0]   ax_q, ay_q;
    logic [B_W-1:0]   bx_q, by_q;
    logic             acc_en1_q, chain_en1_q;
    // Stage 2
    logic             v2_q;
    logic [ACC_W-1:0] p2_q, p2_d;
    logic             acc_en2_q, chain_en2_q;
    // Stage 3
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;
    logic [RES_W-1:0] resulta_q, resulta_c;

    logic [PW-1:0]    ax_e, bx_e, ay_e, by_e, px, py;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] base, chn;
    logic [XW-1:0]    base_x, p_x, chn_x, tot;
    logic             of;

    // Operands are widened to the product width first so a plain multiply
    // yields the correct two's-complement or unsigned product.
    always_comb begin
        ax_e = {{B_W{SIGNED & ax_q[A_W-1]}}, ax_q};
        bx_e = {{A_W{SIGNED & bx_q[B_W-1]}}, bx_q};
        ay_e = {{B_W{SIGNED & ay_q[A_W-1]}}, ay_q};
        by_e = {{A_W{SIGNED & by_q[B_W-1]}}, by_q};
        px   = ax_e * bx_e;
        py   = ay_e * by_e;
        sum  = {SIGNED & px[PW-1], px} + {SIGNED & py[PW-1], py};
        p2_d = SIGNED ? ACC_W'(sext(MAX_W'(sum), SW)) : ACC_W'(zext(MAX_W'(sum), SW));
    end

    // Accumulate with clear overriding the old accumulator; overflow is
    // detected on the exact sum carried in two extra bits.
    always_comb begin
        base   = (acc_en2_q && !bus.clear) ? acc_q : '0;
        chn    = chain_en2_q ? bus.chainin : '0;
        base_x = {{2{SIGNED & base[ACC_W-1]}}, base};
        p_x    = {{2{SIGNED & p2_q[ACC_W-1]}}, p2_q};
        chn_x  = {{2{SIGNED & chn[ACC_W-1]}}, chn};
        tot    = base_x + p_x + chn_x;
        of     = SIGNED ? ~((&tot[XW-1:ACC_W-1]) | ~(|tot[XW-1:ACC_W-1]))
                        : (|tot[XW-1:ACC_W]);
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (v2_q) begin
            acc_d = tot[ACC_W-1:0];
            ovf_d = (ovf_q & ~bus.clear) | of;
        end else if (bus.clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    dsp_mac_sat #(
        .ACC_W  (ACC_W),
        .RES_W  (RES_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_sat (
        .acc_i (acc_d),
        .res_c (resulta_c)
    );

    // Whole pipeline advances only on enabled cycles.
    always_ff @(posedge clk0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            v1_q        <= 1'b0;
            ax_q        <= '0;
            bx_q        <= '0;
            ay_q        <= '0;
            by_q        <= '0;
            acc_en1_q   <= 1'b0;
            chain_en1_q <= 1'b0;
            v2_q        <= 1'b0;
            p2_q        <= '0;
            acc_en2_q   <= 1'b0;
            chain_en2_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            resulta_q   <= '0;
        end else if (bus.ena) begin
            v1_q        <= bus.in_valid;
            ax_q        <= bus.ax;
            bx_q        <= bus.bx;
            ay_q        <= bus.ay;
            by_q        <= bus.by;
            acc_en1_q   <= bus.accumulate;
            chain_en1_q <= bus.chain_en;
            v2_q        <= v1_q;
            p2_q        <= p2_d;
            acc_en2_q   <= acc_en1_q;
            chain_en2_q <= chain_en1_q;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= v2_q;
            resulta_q   <= resulta_c;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.resulta   = resulta_q;
    assign bus.chainout  = acc_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: signed/saturating and unsigned/truncating instances
// share stimulus and are checked against a transaction-level arithmetic model;
// a third signed instance is fed from the first's chainout for the cascade case.
module tb_dsp_mac_pipe;
    import dsp_mac_pkg::*;

    localparam int unsigned A_W = 8, B_W = 18, ACC_W = 64, RES_W = 27;

    typedef struct {
        logic        en, iv;
        logic [7:0]  ax, ay;
        logic [17:0] bx, by;
        logic        accm, chen;
        logic [63:0] chin;
        logic        clr;
    } stim_t;

    typedef struct {
        int     idx;
        longint ps, pu;
        logic   accm, chen;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W)) s_if ();
    dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W)) u_if ();
    dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W)) d_if ();

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W), .SIGNED(1'b1), .SAT(1'b1))
        u_dut_s (.clk0(clk), .aclr0_n(rst_n), .bus(s_if));
    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W), .SIGNED(1'b0), .SAT(1'b0))
        u_dut_u (.clk0(clk), .aclr0_n(rst_n), .bus(u_if));
    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .RES_W(RES_W), .SIGNED(1'b1), .SAT(1'b1))
        u_dut_d (.clk0(clk), .aclr0_n(rst_n), .bus(d_if));

    assign d_if.chainin = s_if.chainout;

    int          checks = 0;
    int          fails  = 0;
    int          en_cnt = 0;
    txn_t        q[$];
    logic [63:0] acc_s = 64'd0, acc_u = 64'd0;
    logic        ovf_s = 1'b0, ovf_u = 1'b0, exp_ov = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] sat_ref(input logic [63:0] a);
        longint v;
        v = $signed(a);
        if (v > 64'sd67108863) return 27'h3FFFFFF;
        if (v < -64'sd67108864) return 27'h4000000;
        return a[26:0];
    endfunction

    function automatic stim_t mk(input logic en, input logic iv, input logic [7:0] ax,
                                 input logic [17:0] bx, input logic [7:0] ay, input logic [17:0] by,
                                 input logic accm, input logic chen, input logic [63:0] chin,
                                 input logic clr);
        stim_t s;
        s.en = en; s.iv = iv; s.ax = ax; s.bx = bx; s.ay = ay; s.by = by;
        s.accm = accm; s.chen = chen; s.chin = chin; s.clr = clr;
        return s;
    endfunction

    function automatic stim_t idle(input logic en, input logic [63:0] chin, input logic clr);
        return mk(en, 1'b0, 8'd0, 18'd0, 8'd0, 18'd0, 1'b0, 1'b0, chin, clr);
    endfunction

    task automatic apply(input stim_t st);
        s_if.ena = st.en; s_if.in_valid = st.iv; s_if.ax = st.ax; s_if.bx = st.bx;
        s_if.ay = st.ay; s_if.by = st.by; s_if.accumulate = st.accm;
        s_if.chain_en = st.chen; s_if.chainin = st.chin; s_if.clear = st.clr;
        u_if.ena = st.en; u_if.in_valid = st.iv; u_if.ax = st.ax; u_if.bx = st.bx;
        u_if.ay = st.ay; u_if.by = st.by; u_if.accumulate = st.accm;
        u_if.chain_en = st.chen; u_if.chainin = st.chin; u_if.clear = st.clr;
    endtask

    task automatic d_drive(input logic iv, input logic [7:0] ax, input logic [17:0] bx, input logic chen);
        d_if.ena = 1'b1; d_if.in_valid = iv; d_if.ax = ax; d_if.bx = bx;
        d_if.ay = 8'd0; d_if.by = 18'd0; d_if.accumulate = 1'b0;
        d_if.chain_en = chen; d_if.clear = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        acc_s = 64'd0; acc_u = 64'd0; ovf_s = 1'b0; ovf_u = 1'b0; exp_ov = 1'b0;
    endtask

    // One clock: drive, advance the model by one edge, compare every output.
    task automatic cyc(input stim_t st);
        txn_t               t;
        logic [63:0]        base, chv;
        logic signed [65:0] ts, back;
        logic [65:0]        tu;
        apply(st);
        @(posedge clk);
        #1;
        if (st.en) begin
            exp_ov = 1'b0;
            if (q.size() > 0 && q[0].idx + int'(PIPE_LAT) == en_cnt + 1) begin
                t      = q.pop_front();
                exp_ov = 1'b1;
                chv    = t.chen ? st.chin : 64'd0;
                base   = (t.accm && !st.clr) ? acc_s : 64'd0;
                ts     = 66'($signed(base)) + 66'(t.ps) + 66'($signed(chv));
                back   = 66'($signed(ts[63:0]));
                ovf_s  = (ovf_s && !st.clr) || (back != ts);
                acc_s  = ts[63:0];
                base   = (t.accm && !st.clr) ? acc_u : 64'd0;
                tu     = {2'b00, base} + {2'b00, 64'(t.pu)} + {2'b00, chv};
                ovf_u  = (ovf_u && !st.clr) || (tu[65:64] != 2'b00);
                acc_u  = tu[63:0];
            end else if (st.clr) begin
                acc_s = 64'd0; acc_u = 64'd0; ovf_s = 1'b0; ovf_u = 1'b0;
            end
            if (st.iv) begin
                t.idx  = en_cnt;
                t.ps   = longint'($signed(st.ax)) * longint'($signed(st.bx))
                       + longint'($signed(st.ay)) * longint'($signed(st.by));
                t.pu   = longint'(st.ax) * longint'(st.bx) + longint'(st.ay) * longint'(st.by);
                t.accm = st.accm;
                t.chen = st.chen;
                q.push_back(t);
            end
            en_cnt++;
        end
        check("s_valid",    64'(s_if.out_valid), 64'(exp_ov));
        check("s_chainout", s_if.chainout,       acc_s);
        check("s_resulta",  64'(s_if.resulta),   64'(sat_ref(acc_s)));
        check("s_ovf",      64'(s_if.ovf),       64'(ovf_s));
        check("u_valid",    64'(u_if.out_valid), 64'(exp_ov));
        check("u_chainout", u_if.chainout,       acc_u);
        check("u_resulta",  64'(u_if.resulta),   64'(acc_u[26:0]));
        check("u_ovf",      64'(u_if.ovf),       64'(ovf_u));
    endtask

    task automatic drain(input int n, input logic [63:0] chin);
        for (int i = 0; i < n; i++) cyc(idle(1'b1, chin, 1'b0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_valid"}, 64'(s_if.out_valid), 64'd0);
        check({tag, "_s_res"},   64'(s_if.resulta),   64'd0);
        check({tag, "_s_chain"}, s_if.chainout,       64'd0);
        check({tag, "_s_ovf"},   64'(s_if.ovf),       64'd0);
        check({tag, "_u_chain"}, u_if.chainout,       64'd0);
        check({tag, "_u_valid"}, 64'(u_if.out_valid), 64'd0);
        check({tag, "_d_chain"}, d_if.chainout,       64'd0);
        check({tag, "_d_valid"}, 64'(d_if.out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] seen[$];
        logic [63:0] exp2 [4];
        logic [63:0] chin;
        stim_t       st;

        apply(idle(1'b1, 64'd0, 1'b0));
        d_drive(1'b0, 8'd0, 18'd0, 1'b0);
        #12;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction: 3*5 + 2*7 visible on the third edge.
        cyc(mk(1'b1, 1'b1, 8'd3, 18'd5, 8'd2, 18'd7, 1'b0, 1'b0, 64'd0, 1'b0));
        check("t1_lat1", 64'(s_if.out_valid), 64'd0);
        cyc(idle(1'b1, 64'd0, 1'b0));
        check("t1_lat2", 64'(s_if.out_valid), 64'd0);
        cyc(idle(1'b1, 64'd0, 1'b0));
        check("t1_lat3", 64'(s_if.out_valid), 64'd1);
        check("t1_res",  64'(s_if.resulta),   64'd29);
        check("t1_chain", s_if.chainout,      64'd29);
        check("t1_ovf",  64'(s_if.ovf),       64'd0);
        drain(2, 64'd0);

        // Four back-to-back accumulating transactions.
        exp2 = '{64'd29, 64'd58, 64'd87, 64'd116};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) cyc(mk(1'b1, 1'b1, 8'd3, 18'd5, 8'd2, 18'd7, (i != 0), 1'b0, 64'd0, 1'b0));
            else       cyc(idle(1'b1, 64'd0, 1'b0));
            if (s_if.out_valid) seen.push_back(s_if.resulta);
        end
        check("t2_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check("t2_res", 64'(seen[i]), exp2[i]);
        drain(2, 64'd0);

        // Two stalled cycles stretch the latency to five edges.
        cyc(mk(1'b1, 1'b1, 8'd3, 18'd5, 8'd2, 18'd7, 1'b0, 1'b0, 64'd0, 1'b0));
        cyc(idle(1'b1, 64'd0, 1'b0));
        cyc(idle(1'b0, 64'd0, 1'b0));
        cyc(idle(1'b0, 64'd0, 1'b0));
        check("t3_frozen", 64'(s_if.out_valid), 64'd0);
        cyc(idle(1'b1, 64'd0, 1'b0));
        check("t3_valid", 64'(s_if.out_valid), 64'd1);
        check("t3_res",   64'(s_if.resulta),   64'd29);
        drain(2, 64'd0);

        // Signed saturation: each product-sum is 2^25.
        for (int i = 0; i < 4; i++)
            cyc(mk(1'b1, 1'b1, 8'h80, 18'h20000, 8'h80, 18'h20000, (i != 0), 1'b0, 64'd0, 1'b0));
        drain(4, 64'd0);
        check("t4_res",   64'(s_if.resulta), 64'h3FFFFFF);
        check("t4_chain", s_if.chainout,     64'h8000000);
        check("t4_ovf",   64'(s_if.ovf),     64'd0);

        // Cascade: downstream presents its operands one cycle later.
        cyc(mk(1'b1, 1'b1, 8'd3, 18'd5, 8'd0, 18'd0, 1'b0, 1'b0, 64'd0, 1'b0));
        d_drive(1'b1, 8'd2, 18'd7, 1'b1);
        cyc(idle(1'b1, 64'd0, 1'b0));
        d_drive(1'b0, 8'd0, 18'd0, 1'b0);
        drain(4, 64'd0);
        check("t5_up",    s_if.chainout,     64'd15);
        check("t5_chain", d_if.chainout,     64'd29);
        check("t5_res",   64'(d_if.resulta), 64'd29);

        // Signed overflow is sticky; clear with a valid update restarts from p.
        chin = 64'h7FFF_FFFF_FFFF_FFFF;
        cyc(mk(1'b1, 1'b1, 8'd0, 18'd0, 8'd0, 18'd0, 1'b0, 1'b1, chin, 1'b0));
        cyc(mk(1'b1, 1'b1, 8'd1, 18'd1, 8'd0, 18'd0, 1'b1, 1'b0, chin, 1'b0));
        drain(3, chin);
        check("t6_wrap", s_if.chainout,  64'h8000_0000_0000_0000);
        check("t6_ovf",  64'(s_if.ovf),  64'd1);
        drain(2, chin);
        check("t6_sticky", 64'(s_if.ovf), 64'd1);
        cyc(mk(1'b1, 1'b1, 8'd2, 18'd2, 8'd0, 18'd0, 1'b1, 1'b0, chin, 1'b0));
        cyc(idle(1'b1, chin, 1'b0));
        cyc(idle(1'b1, chin, 1'b1));
        check("t6_clr_valid", 64'(s_if.out_valid), 64'd1);
        check("t6_clr_acc",   s_if.chainout,       64'd4);
        check("t6_clr_ovf",   64'(s_if.ovf),       64'd0);
        drain(2, chin);

        // Randomised phases, each ending with a clear on an idle pipeline.
        for (int ph = 0; ph < 4; ph++) begin
            chin = (ph == 0) ? 64'($urandom_range(0, 65535)) : {$urandom, $urandom};
            for (int i = 0; i < 300; i++) begin
                st = mk(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 7),
                        8'($urandom), 18'($urandom), 8'($urandom), 18'($urandom),
                        ($urandom_range(0, 3) != 0), 1'($urandom), chin, 1'b0);
                cyc(st);
                if (ph == 2 && i == 150) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero("midrst");
                    model_reset();
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
            drain(4, chin);
            cyc(idle(1'b1, chin, 1'b1));
            check("ph_clr_acc", s_if.chainout, 64'd0);
            check("ph_clr_ovf", 64'(u_if.ovf), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised, pipelined dual-product multiply-accumulate for the BrAMAC datapath. Computes ax*bx + ay*by, optionally adds a cascade input and the running accumulator, and drives a full-width cascade output plus a narrow (optionally saturated) result. Fixed-latency valid pipeline with a global stall, sticky overflow and a synchronous clear.

Parameters:
A_W, 8, width of ax/ay operands
B_W, 18, width of bx/by operands
ACC_W, 64, accumulator and chain width; must be >= A_W+B_W+1
RES_W, 27, resulta width; must be <= ACC_W
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
SAT, 1, 1 = resulta saturates to RES_W range, 0 = resulta truncates to acc[RES_W-1:0]

Ports:
clk0  in  1  single clock, rising edge
aclr0_n  in  1  asynchronous active-low reset
ena  in  1  global clock enable; low freezes every register
in_valid  in  1  operand set valid this cycle
ax  in  A_W  operand A, product X
bx  in  B_W  operand B, product X
ay  in  A_W  operand A, product Y
by  in  B_W  operand B, product Y
accumulate  in  1  1 = add into running accumulator, 0 = load
chain_en  in  1  1 = add chainin at stage 3
chainin  in  ACC_W  cascade input from upstream chainout
clear  in  1  synchronous clear of accumulator and overflow
out_valid  out  1  resulta/chainout updated with a valid result
resulta  out  RES_W  narrow result
chainout  out  ACC_W  full accumulator, for cascade
ovf  out  1  sticky accumulator overflow

Behaviour:
- Reset (aclr0_n=0, asynchronous): all stage registers, acc, out_valid, resulta, chainout, ovf = 0.
- All registers update only on clk0 rising edge with ena=1; ena=0 holds every register, including the valid pipeline.
- Stage 1: register ax, bx, ay, by, accumulate, chain_en, and in_valid (as v1).
- Stage 2: p = ext(ax*bx) + ext(ay*by). Each product is A_W+B_W bits and the sum is A_W+B_W+1 bits, sign- or zero-extended per SIGNED to ACC_W. Flags are pipelined as v2.
- Stage 3 (when v2=1): acc <= (accumulate_s2 ? acc : 0) + p + (chain_en_s2 ? chainin : 0), wrapping mod 2^ACC_W. chainin is sampled in this cycle.
- Stage 3 when v2=0: acc is held and out_valid=0.
- Latency: 3 enabled cycles from in_valid to out_valid. Throughput: 1 per enabled cycle.
- out_valid is the registered v2. chainout = acc. resulta is derived from acc:
  - SAT=1: clamp to the RES_W signed (SIGNED=1) or unsigned range.
  - SAT=0: acc[RES_W-1:0].
- ovf: set on any stage-3 update whose true sum overflows ACC_W (signed or unsigned per SIGNED). Sticky until clear or reset. Saturation of resulta does not set ovf.
- clear (sampled directly, not pipelined, with ena=1): acc <= 0 and ovf <= 0 next edge. In-flight stage-1/2 data is unaffected.
- clear together with a stage-3 valid update: clear wins for the old state. acc <= p + (chain_en ? chainin : 0), and ovf is evaluated on that sum only. out_valid=1.
- Cascade: chainout is registered. A downstream instance must present its operands one cycle later than the upstream instance for chainin to align.
- Mid-operation reset clears everything; there is no partial result recovery.

Decomposition:
- Shared package dsp_mac_pkg holds:
  - function sext/zext to ACC_W
  - localparam PIPE_LAT = 3
  - saturation bound helper functions
- One sub-module, dsp_mac_sat: combinational ACC_W -> RES_W saturate/truncate with SAT and SIGNED parameters.

Test Plan:
- Reset, then ax=3,bx=5,ay=2,by=7, in_valid=1, accumulate=0 -> out_valid exactly 3 cycles later, resulta=29, chainout=29, ovf=0.
- Four back-to-back valids of the same operands with accumulate=1 (first with accumulate=0) -> out_valid on 4 consecutive cycles, resulta 29, 58, 87, 116.
- ena=0 for 2 cycles mid-stream -> outputs and pipeline frozen, sequence resumes unchanged, total latency 5 cycles.
- SIGNED=1: ax=-128, bx=-131072, ay=-128, by=-131072 repeated with accumulate=1 -> resulta saturates at 2^26-1 once acc > 67108863, chainout shows the true value, ovf=0.
- Two cascaded instances (downstream skewed one cycle, chain_en=1): upstream 3*5, downstream 2*7 -> downstream chainout=29.
- acc=0x7FFF...FFFF (SIGNED=1), add p=1 -> chainout=0x8000...0000, ovf=1 and stays 1. Then clear with a valid update p=4 -> acc=4, ovf=0.
